// File: rtl/serial_adder_pkg.sv
// Shared definitions for the bit-serial adder.
// Holds the FSM state encoding, the default operand width and a helper
// that sizes the bit counter so that a one-bit build still gets a real
// one-bit counter instead of a zero-width one.
package serial_adder_pkg;

    localparam int DEFAULT_WIDTH = 8;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    // Counter width: clog2 of the operand width, never below one bit.
    function automatic int cnt_width(input int w);
        int r;
        if (w > 1) begin
            r = $clog2(w);
        end else begin
            r = 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/full_adder.sv
// One-bit full adder used as the arithmetic step of the serial adder.
// Ports:
//   a_i, b_i  : operand bits
//   cin_i     : carry in
//   sum_o     : sum bit
//   cout_o    : carry out
module full_adder (
    input  logic a_i,
    input  logic b_i,
    input  logic cin_i,
    output logic sum_o,
    output logic cout_o
);

    assign sum_o  = a_i ^ b_i ^ cin_i;
    assign cout_o = (a_i & b_i) | (a_i & cin_i) | (b_i & cin_i);

endmodule

// File: rtl/serial_adder.sv
// Bit-serial adder: computes {cout,sum} = a + b + cin one bit per clock.
// An accepted start captures the operands into right-shifting registers;
// each RUN cycle feeds the two LSBs and the carry flop through a single
// full adder and shifts the sum bit into the result register from the MSB
// side. After WIDTH steps the result is published and done pulses once.
// Ports:
//   clk, rst_n     : clock, asynchronous active-low reset
//   start          : add request, only honoured in IDLE
//   a, b, cin      : operands and carry in, captured on accepted start
//   busy           : high in RUN and DONE
//   done           : one-cycle completion pulse
//   sum, cout      : registered result, held until the next result
module serial_adder
    import serial_adder_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);

    localparam int CNT_W = cnt_width(WIDTH);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    state_e           state_q, state_d;
    logic [WIDTH-1:0] a_sr_q, a_sr_d;
    logic [WIDTH-1:0] b_sr_q, b_sr_d;
    logic             carry_q, carry_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] res_q, res_d;
    logic [WIDTH-1:0] sum_q, sum_d;
    logic             cout_q, cout_d;

    logic             fa_sum_s;
    logic             fa_carry_s;
    logic [WIDTH:0]   res_cat_s;
    logic [WIDTH-1:0] res_next_s;

    full_adder u_fa (
        .a_i    (a_sr_q[0]),
        .b_i    (b_sr_q[0]),
        .cin_i  (carry_q),
        .sum_o  (fa_sum_s),
        .cout_o (fa_carry_s)
    );

    // Sum bit enters at the MSB; the concatenate-and-slice form also works
    // for a one-bit build where a [WIDTH-1:1] slice would be empty.
    assign res_cat_s  = {fa_sum_s, res_q};
    assign res_next_s = res_cat_s[WIDTH:1];

    // Next-state and datapath update for the IDLE/RUN/DONE sequence.
    always_comb begin
        state_d = state_q;
        a_sr_d  = a_sr_q;
        b_sr_d  = b_sr_q;
        carry_d = carry_q;
        cnt_d   = cnt_q;
        res_d   = res_q;
        sum_d   = sum_q;
        cout_d  = cout_q;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d = ST_RUN;
                    a_sr_d  = a;
                    b_sr_d  = b;
                    carry_d = cin;
                    cnt_d   = {CNT_W{1'b0}};
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_RUN: begin
                a_sr_d  = a_sr_q >> 1'b1;
                b_sr_d  = b_sr_q >> 1'b1;
                carry_d = fa_carry_s;
                res_d   = res_next_s;
                if (cnt_q == CNT_LAST) begin
                    // Last bit: publish the result; counter holds, no wrap.
                    state_d = ST_DONE;
                    sum_d   = res_next_s;
                    cout_d  = fa_carry_s;
                end else begin
                    cnt_d   = cnt_q + CNT_ONE;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and datapath registers, all cleared by reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            a_sr_q  <= {WIDTH{1'b0}};
            b_sr_q  <= {WIDTH{1'b0}};
            carry_q <= 1'b0;
            cnt_q   <= {CNT_W{1'b0}};
            res_q   <= {WIDTH{1'b0}};
            sum_q   <= {WIDTH{1'b0}};
            cout_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            a_sr_q  <= a_sr_d;
            b_sr_q  <= b_sr_d;
            carry_q <= carry_d;
            cnt_q   <= cnt_d;
            res_q   <= res_d;
            sum_q   <= sum_d;
            cout_q  <= cout_d;
        end
    end

    assign busy = (state_q == ST_RUN) || (state_q == ST_DONE);
    assign done = (state_q == ST_DONE);
    assign sum  = sum_q;
    assign cout = cout_q;

endmodule

// File: tb/tb_serial_adder.sv
// Scoreboard bench for serial_adder: an 8-bit and a 1-bit instance.
// Stimulus pushes the hand-computed result and the cycle at which done is
// expected; a negedge monitor pops and compares on every done pulse.
module tb_serial_adder;

    typedef struct {
        logic [7:0] s;
        logic       c;
        int         cyc;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    int         cyc = 0;
    int         tests = 0;
    int         fails = 0;

    logic       start8 = 1'b0;
    logic [7:0] a8 = 8'h00, b8 = 8'h00;
    logic       cin8 = 1'b0;
    logic       busy8, done8, cout8;
    logic [7:0] sum8;

    logic       start1 = 1'b0;
    logic [0:0] a1 = 1'b0, b1 = 1'b0;
    logic       cin1 = 1'b0;
    logic       busy1, done1, cout1;
    logic [0:0] sum1;

    exp_t q8[$];
    exp_t q1[$];

    logic [1:0] fa_tab [8] = '{2'b00, 2'b01, 2'b01, 2'b10,
                               2'b01, 2'b10, 2'b10, 2'b11};

    serial_adder #(.WIDTH(8)) dut8 (
        .clk(clk), .rst_n(rst_n), .start(start8), .a(a8), .b(b8), .cin(cin8),
        .busy(busy8), .done(done8), .sum(sum8), .cout(cout8)
    );

    serial_adder #(.WIDTH(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .start(start1), .a(a1), .b(b1), .cin(cin1),
        .busy(busy1), .done(done1), .sum(sum1), .cout(cout1)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h (cyc %0d)", nm, act, exp, cyc);
        end
    endtask

    // Monitor: every done pulse is matched against the scoreboard head.
    always @(negedge clk) begin
        exp_t e;
        if (rst_n && done8) begin
            if (q8.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL w8_unexpected_done: got done at cyc %0d expected none", cyc);
            end else begin
                e = q8.pop_front();
                chk("w8_sum", 32'(sum8), 32'(e.s));
                chk("w8_cout", 32'(cout8), 32'(e.c));
                chk("w8_done_cycle", cyc, e.cyc);
                chk("w8_busy_at_done", 32'(busy8), 32'd1);
            end
        end
        if (rst_n && done1) begin
            if (q1.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL w1_unexpected_done: got done at cyc %0d expected none", cyc);
            end else begin
                e = q1.pop_front();
                chk("w1_sum", 32'(sum1), 32'(e.s[0]));
                chk("w1_cout", 32'(cout1), 32'(e.c));
                chk("w1_done_cycle", cyc, e.cyc);
            end
        end
    end

    task automatic wait_idle8();
        int n = 0;
        @(negedge clk);
        while (busy8 && n < 40) begin
            @(negedge clk);
            n++;
        end
        if (busy8) chk("w8_idle_timeout", 32'(busy8), 32'd0);
    endtask

    task automatic wait_idle1();
        int n = 0;
        @(negedge clk);
        while (busy1 && n < 40) begin
            @(negedge clk);
            n++;
        end
        if (busy1) chk("w1_idle_timeout", 32'(busy1), 32'd0);
    endtask

    // Issue one add on the 8-bit instance at the current negedge.
    task automatic issue8(input logic [7:0] a, input logic [7:0] b, input logic c,
                          input logic [7:0] es, input logic ec);
        exp_t e;
        a8 = a; b8 = b; cin8 = c; start8 = 1'b1;
        e.s = es; e.c = ec; e.cyc = cyc + 1 + 8;
        q8.push_back(e);
        @(negedge clk);
        start8 = 1'b0;
    endtask

    task automatic add8(input logic [7:0] a, input logic [7:0] b, input logic c,
                        input logic [7:0] es, input logic ec);
        wait_idle8();
        issue8(a, b, c, es, ec);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        exp_t e;
        int   n;
        repeat (3) @(negedge clk);
        chk("rst_busy", 32'(busy8), 32'd0);
        chk("rst_done", 32'(done8), 32'd0);
        chk("rst_sum", 32'(sum8), 32'd0);
        chk("rst_cout", 32'(cout8), 32'd0);

        // Release at a negedge; the next edge must accept the start.
        rst_n = 1'b1;
        issue8(8'h00, 8'h00, 1'b0, 8'h00, 1'b0);
        add8(8'hFF, 8'h01, 1'b0, 8'h00, 1'b1);
        add8(8'h55, 8'h2A, 1'b0, 8'h7F, 1'b0);
        add8(8'h80, 8'h7F, 1'b1, 8'h00, 1'b1);
        add8(8'hA5, 8'h5A, 1'b1, 8'h00, 1'b1);

        // Operand change and stray start during RUN are ignored.
        add8(8'h3C, 8'h0F, 1'b0, 8'h4B, 1'b0);
        @(negedge clk);
        chk("run_sum_hold", 32'(sum8), 32'h00);
        chk("run_cout_hold", 32'(cout8), 32'd1);
        chk("run_busy", 32'(busy8), 32'd1);
        a8 = 8'hFF; start8 = 1'b1;
        @(negedge clk);
        start8 = 1'b0;

        // Reset while RUN is on bit 4: abort, no done.
        wait_idle8();
        a8 = 8'h77; b8 = 8'h11; cin8 = 1'b0; start8 = 1'b1;
        @(negedge clk);
        start8 = 1'b0;
        repeat (4) @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("abort_busy", 32'(busy8), 32'd0);
        chk("abort_done", 32'(done8), 32'd0);
        chk("abort_sum", 32'(sum8), 32'd0);
        chk("abort_cout", 32'(cout8), 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        issue8(8'h01, 8'h02, 1'b0, 8'h03, 1'b0);

        // Start held high: second acceptance WIDTH+2 cycles after the first.
        wait_idle8();
        a8 = 8'h10; b8 = 8'h20; cin8 = 1'b0; start8 = 1'b1;
        e.s = 8'h30; e.c = 1'b0; e.cyc = cyc + 1 + 8;
        q8.push_back(e);
        e.s = 8'h00; e.c = 1'b1; e.cyc = cyc + 1 + 10 + 8;
        q8.push_back(e);
        @(negedge clk);
        a8 = 8'h80; b8 = 8'h80;
        repeat (10) @(negedge clk);
        start8 = 1'b0;

        // One-bit build: full-adder truth table, done one edge after accept.
        for (int i = 0; i < 8; i++) begin
            logic [2:0] v;
            v = 3'(i);
            wait_idle1();
            a1 = v[2]; b1 = v[1]; cin1 = v[0]; start1 = 1'b1;
            e.s = {7'h00, fa_tab[i][0]}; e.c = fa_tab[i][1]; e.cyc = cyc + 1 + 1;
            q1.push_back(e);
            @(negedge clk);
            start1 = 1'b0;
        end

        n = 0;
        while ((q8.size() != 0 || q1.size() != 0) && n < 60) begin
            @(negedge clk);
            n++;
        end
        repeat (3) @(negedge clk);
        chk("w8_scoreboard_empty", 32'(q8.size()), 32'd0);
        chk("w1_scoreboard_empty", 32'(q1.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/serial_adder.md
SERIAL_ADDER -- requirements
Module: serial_adder

Interface
REQ-001 Parameter: WIDTH, default 8, operand/sum bit width (>=1).
REQ-002 clk  input  1  rising-edge clock, sole clock domain.
REQ-003 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-004 start  input  1  request to add current a/b/cin; sampled only in IDLE.
REQ-005 a  input  WIDTH  operand A, captured on accepted start.
REQ-006 b  input  WIDTH  operand B, captured on accepted start.
REQ-007 cin  input  1  carry-in, captured on accepted start.
REQ-008 busy  output  1  high while in RUN or DONE.
REQ-009 done  output  1  single-cycle completion pulse.
REQ-010 sum  output  WIDTH  registered result, valid from done until next accepted start.
REQ-011 cout  output  1  registered carry-out, same validity as sum.

Function
REQ-012 FSM states: IDLE, RUN, DONE; reset state IDLE.
REQ-013 IDLE + start=1 at a rising edge -> RUN; shift regs load a, b; carry flop loads cin; bit counter = 0.
REQ-014 IDLE + start=0 -> stay IDLE, no register change.
REQ-015 Each RUN edge: one full-adder step on a_sr[0], b_sr[0], carry flop; sum bit shifts into result shift reg from MSB side; a_sr/b_sr shift right; carry flop takes carry out; counter +1.
REQ-016 RUN edge with counter = WIDTH-1 -> DONE; sum <= completed result shift reg, cout <= final carry.
REQ-017 Latency: done high exactly in the cycle following the (WIDTH+1)th rising edge counting the edge that accepted start; done high for one cycle only.
REQ-018 DONE -> IDLE unconditionally on next edge; start during RUN or DONE ignored, operands not recaptured.
REQ-019 Back-to-back: start held high continuously yields a new acceptance on the first edge after return to IDLE (throughput one add per WIDTH+2 cycles).
REQ-020 sum/cout unchanged during RUN; they update only on RUN->DONE and hold thereafter.
REQ-021 Arithmetic: {cout,sum} = a + b + cin, modulo 2^(WIDTH+1), no overflow flag.
REQ-022 Counter width = clog2(WIDTH) bits minimum, 1 bit when WIDTH=1; no wrap within an operation.
REQ-023 Input changes on a/b/cin after acceptance have no effect on the result.

Reset
REQ-024 rst_n low forces immediately: state IDLE, busy=0, done=0, sum=0, cout=0, shift regs, carry flop, counter all 0.
REQ-025 Reset mid-RUN aborts the operation; no done pulse is produced for it.
REQ-026 First start is accepted on the first rising edge after rst_n deasserts.

Structure
REQ-027 Shared package serial_adder_pkg holds FSM state encoding (2-bit: IDLE=0, RUN=1, DONE=2) and default WIDTH constant.
REQ-028 Bit step is one instance of the existing full_adder sub-module (inputs a, b, carry-in; outputs sum, carry); no other sub-modules.
REQ-029 All state in a single clk/rst_n domain; busy and done decoded from registered state only.

Verification (WIDTH=8)
REQ-030 a=8'h00, b=8'h00, cin=0, start pulse -> done at edge 9 after accept, sum=8'h00, cout=0.
REQ-031 a=8'hFF, b=8'h01, cin=0 -> sum=8'h00, cout=1; a=8'hA5, b=8'h5A, cin=1 -> sum=8'h00, cout=1.
REQ-032 a=8'h3C, b=8'h0F, cin=0, then change a to 8'hFF and pulse start during RUN -> sum=8'h4B, cout=0, single done, busy timing unchanged.
REQ-033 rst_n low at RUN bit 4 of a=8'h77+b=8'h11 -> all outputs 0 immediately, no done; next add 8'h01+8'h02 -> sum=8'h03.
REQ-034 start held high, operands 8'h10+8'h20 then 8'h80+8'h80 -> two done pulses 10 cycles apart, results 8'h30/cout0 then 8'h00/cout1.
REQ-035 WIDTH=1 build: all 8 a/b/cin combinations -> {cout,sum} equals full-adder truth table, done 2 edges after accept.
